cache_level_responder: RTL and testbench

- Responder side of the cache-level request interface: one direct-mapped cache level (L1/L2 class) that accepts a single read or write request from the cache controller and answers with hit/miss and data after a fixed, parameterised latency.
- Replaces the free-running, clock-gated cache levels with an explicit valid/ready request and valid response handshake.
- Only one request is outstanding at a time.

---
 rtl/cache_level_responder_if.sv | 25 ++
 rtl/cache_level_responder.sv | 176 +++++++++++++++++
 tb/tb_cache_level_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_level_responder_if.sv
// Request/response bundle between a cache controller (master) and one cache level (slave).
interface cache_level_responder_if #(
   parameter int WORD_SIZE = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_wr;
   logic [WORD_SIZE-1:0] req_addr;
   logic [WORD_SIZE-1:0] req_wdata;
   logic                 resp_valid;
   logic                 resp_hit;
   logic [WORD_SIZE-1:0] resp_rdata;
   logic [15:0]          hit_count;
   logic [15:0]          miss_count;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_hit, resp_rdata, hit_count, miss_count
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata,
      output req_ready, resp_valid, resp_hit, resp_rdata, hit_count, miss_count
   );
endinterface

// File: rtl/cache_level_responder.sv
// Direct-mapped, one-word-per-line cache level answering one request at a time after LATENCY cycles.
// Optional read hit/miss statistics are built when CACHE_STATS_EN is defined.
module cache_level_responder #(
   parameter int WORD_SIZE = 32,
   parameter int LINES     = 16,
   parameter int LATENCY   = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   cache_level_responder_if.slave  bus
);
   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = WORD_SIZE - INDEX_W - 2;
   localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_wr;
   logic [WORD_SIZE-1:0] r_addr;
   logic [WORD_SIZE-1:0] r_wdata;
   logic [LINES-1:0]     r_valid;
   logic [TAG_W-1:0]     r_tag  [LINES];
   logic [WORD_SIZE-1:0] r_data [LINES];
   logic                 r_resp_valid;
   logic                 r_resp_hit;
   logic [WORD_SIZE-1:0] r_resp_rdata;

   logic                 w_accept;
   logic                 w_enter_resp;
   logic                 w_eff_wr;
   logic [WORD_SIZE-1:0] w_eff_addr;
   logic [WORD_SIZE-1:0] w_eff_wdata;
   logic [INDEX_W-1:0]   w_index;
   logic [TAG_W-1:0]     w_tag;
   logic                 w_lookup_hit;
   logic                 w_unused_ok;

   // With LATENCY=1 the response is formed on the accepting edge, so look up the live request then.
   always_comb begin
      w_eff_wr    = r_wr;
      w_eff_addr  = r_addr;
      w_eff_wdata = r_wdata;
      if (r_state == S_IDLE) begin
         w_eff_wr    = bus.req_wr;
         w_eff_addr  = bus.req_addr;
         w_eff_wdata = bus.req_wdata;
      end else begin
         w_eff_wr    = r_wr;
         w_eff_addr  = r_addr;
         w_eff_wdata = r_wdata;
      end
   end

   assign w_index      = w_eff_addr[INDEX_W+1:2];
   assign w_tag        = w_eff_addr[WORD_SIZE-1:INDEX_W+2];
   assign w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_unused_ok  = &{1'b0, w_eff_addr[1:0]};

   // Next-state and strobe decode.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_enter_resp = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               w_accept = 1'b1;
               if (LATENCY == 1) begin
                  w_next_state = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_next_state = S_BUSY;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_BUSY: begin
            if (r_cnt == CNT_ONE) begin
               w_next_state = S_RESP;
               w_enter_resp = 1'b1;
            end else begin
               w_next_state = S_BUSY;
            end
         end
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State, latency counter, line valid bits and response registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_valid      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_cnt <= CNT_LOAD;
         end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - CNT_ONE;
         end
         if (w_enter_resp && w_eff_wr) begin
            r_valid[w_index] <= 1'b1;
         end
         r_resp_valid <= w_enter_resp;
         r_resp_hit   <= w_enter_resp && (w_eff_wr || w_lookup_hit);
         r_resp_rdata <= (w_enter_resp && !w_eff_wr && w_lookup_hit) ? r_data[w_index] : '0;
      end
   end

   // Request capture; contents only matter once the matching state is entered.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_wr    <= bus.req_wr;
         r_addr  <= bus.req_addr;
         r_wdata <= bus.req_wdata;
      end
   end

   // Tag/data arrays are not reset; the valid bits alone qualify them.
   always_ff @(posedge i_clk) begin
      if (i_rst && w_enter_resp && w_eff_wr) begin
         r_tag[w_index]  <= w_tag;
         r_data[w_index] <= w_eff_wdata;
      end
   end

   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_hit   = r_resp_hit;
   assign bus.resp_rdata = r_resp_rdata;

`ifdef CACHE_STATS_EN
   logic [15:0] r_hit_count;
   logic [15:0] r_miss_count;

   // Saturating read hit/miss counters.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_hit_count  <= 16'd0;
         r_miss_count <= 16'd0;
      end else if (w_enter_resp && !w_eff_wr) begin
         if (w_lookup_hit) begin
            if (r_hit_count != 16'hFFFF) begin
               r_hit_count <= r_hit_count + 16'd1;
            end
         end else begin
            if (r_miss_count != 16'hFFFF) begin
               r_miss_count <= r_miss_count + 16'd1;
            end
         end
      end
   end

   assign bus.hit_count  = r_hit_count;
   assign bus.miss_count = r_miss_count;
`else
   assign bus.hit_count  = 16'd0;
   assign bus.miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_level_responder.sv
// Directed bench: a LATENCY=3 and a LATENCY=1 responder sharing one request driver.
module tb_cache_level_responder;
`ifdef CACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        sel;
   logic        d_valid;
   logic        d_wr;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;

   cache_level_responder_if #(.WORD_SIZE(32)) bus3 ();
   cache_level_responder_if #(.WORD_SIZE(32)) bus1 ();

   assign bus3.req_valid = d_valid & ~sel;
   assign bus3.req_wr    = d_wr;
   assign bus3.req_addr  = d_addr;
   assign bus3.req_wdata = d_wdata;
   assign bus1.req_valid = d_valid & sel;
   assign bus1.req_wr    = d_wr;
   assign bus1.req_addr  = d_addr;
   assign bus1.req_wdata = d_wdata;

   cache_level_responder #(.WORD_SIZE(32), .LINES(16), .LATENCY(3)) dut3 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus3)
   );

   cache_level_responder #(.WORD_SIZE(32), .LINES(16), .LATENCY(1)) dut1 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus1)
   );

   logic        o_ready, o_resp_valid, o_resp_hit;
   logic [31:0] o_resp_rdata;
   logic [15:0] o_hit_cnt, o_miss_cnt;
   assign o_ready      = sel ? bus1.req_ready  : bus3.req_ready;
   assign o_resp_valid = sel ? bus1.resp_valid : bus3.resp_valid;
   assign o_resp_hit   = sel ? bus1.resp_hit   : bus3.resp_hit;
   assign o_resp_rdata = sel ? bus1.resp_rdata : bus3.resp_rdata;
   assign o_hit_cnt    = sel ? bus1.hit_count  : bus3.hit_count;
   assign o_miss_cnt   = sel ? bus1.miss_count : bus3.miss_count;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Issue one request at a negedge with the DUT idle; ends at the negedge after the response.
   task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int busy_cyc, output logic hit, output logic [31:0] rdata);
      d_valid = 1'b1;
      d_wr    = wr;
      d_addr  = addr;
      d_wdata = wdata;
      @(posedge clk);
      #1;
      d_valid  = 1'b0;
      d_wr     = 1'b1;
      d_addr   = 32'hFFFF_FFFC;
      d_wdata  = 32'h0;
      lat      = 0;
      busy_cyc = 0;
      hit      = 1'b0;
      rdata    = 32'h0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (!o_ready) busy_cyc++;
         if (o_resp_valid) begin
            lat   = k;
            hit   = o_resp_hit;
            rdata = o_resp_rdata;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic req_check(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic exp_hit,
                            input logic [31:0] exp_rdata, input int exp_lat);
      int          lat, busy_cyc;
      logic        hit;
      logic [31:0] rdata;
      do_req(wr, addr, wdata, lat, busy_cyc, hit, rdata);
      check({tag, ".latency"},    32'(lat), 32'(exp_lat));
      check({tag, ".ready_low"},  32'(busy_cyc), 32'(exp_lat));
      check({tag, ".hit"},        {31'd0, hit}, {31'd0, exp_hit});
      check({tag, ".rdata"},      rdata, exp_rdata);
      check({tag, ".ready_after"}, {31'd0, o_ready}, 32'd1);
      check({tag, ".valid_after"}, {31'd0, o_resp_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          n_acc, n_resp, n_stray;
      int          resp_at [2];
      logic [31:0] resp_d  [2];

      sel     = 1'b0;
      d_valid = 1'b0;
      d_wr    = 1'b0;
      d_addr  = 32'h0;
      d_wdata = 32'h0;
      rst     = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      check("reset.ready",      {31'd0, o_ready}, 32'd1);
      check("reset.resp_valid", {31'd0, o_resp_valid}, 32'd0);
      check("reset.resp_hit",   {31'd0, o_resp_hit}, 32'd0);
      check("reset.rdata",      o_resp_rdata, 32'd0);
      check("reset.hit_count",  32'(o_hit_cnt), 32'd0);
      check("reset.miss_count", 32'(o_miss_cnt), 32'd0);

      // Cold miss, then write-allocate and read back.
      req_check("rd40", 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0, 3);
      check("rd40.miss_count", 32'(o_miss_cnt), STATS ? 32'd1 : 32'd0);
      req_check("wr44", 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b1, 32'h0, 3);
      req_check("rd44", 1'b0, 32'h0000_0044, 32'h0, 1'b1, 32'hDEAD_BEEF, 3);
      check("rd44.hit_count", 32'(o_hit_cnt), STATS ? 32'd1 : 32'd0);

      // Same index 2, different tag; byte offset ignored.
      req_check("wr08", 1'b1, 32'h0000_0008, 32'h1111_1111, 1'b1, 32'h0, 3);
      req_check("rd48", 1'b0, 32'h0000_0048, 32'h0, 1'b0, 32'h0, 3);
      req_check("rd0B", 1'b0, 32'h0000_000B, 32'h0, 1'b1, 32'h1111_1111, 3);
      check("conflict.hit_count",  32'(o_hit_cnt),  STATS ? 32'd2 : 32'd0);
      check("conflict.miss_count", 32'(o_miss_cnt), STATS ? 32'd2 : 32'd0);

      // req_valid held high; junk writes to 0x44 presented while busy must be ignored.
      n_acc  = 0;
      n_resp = 0;
      resp_at[0] = -1; resp_at[1] = -1;
      resp_d[0]  = 32'h0; resp_d[1] = 32'h0;
      for (int c = 0; c < 8; c++) begin
         if (o_resp_valid) begin
            if (n_resp < 2) begin
               resp_at[n_resp] = c;
               resp_d[n_resp]  = o_resp_rdata;
            end
            n_resp++;
         end
         if (o_ready) begin
            d_wr    = 1'b0;
            d_addr  = (n_acc % 2 == 0) ? 32'h0000_000B : 32'h0000_0044;
            d_wdata = 32'h0;
            n_acc++;
         end else begin
            d_wr    = 1'b1;
            d_addr  = 32'h0000_0044;
            d_wdata = 32'h0;
         end
         d_valid = 1'b1;
         @(negedge clk);
      end
      d_valid = 1'b0;
      check("hold.accepts",   32'(n_acc), 32'd2);
      check("hold.responses", 32'(n_resp), 32'd2);
      check("hold.resp0_at",  32'(resp_at[0]), 32'd3);
      check("hold.resp1_at",  32'(resp_at[1]), 32'd7);
      check("hold.resp0_d",   resp_d[0], 32'h1111_1111);
      check("hold.resp1_d",   resp_d[1], 32'hDEAD_BEEF);
      req_check("rd44b", 1'b0, 32'h0000_0044, 32'h0, 1'b1, 32'hDEAD_BEEF, 3);
      check("hold.hit_count", 32'(o_hit_cnt), STATS ? 32'd5 : 32'd0);

      // Reset during BUSY of a write: no response, write dropped, all lines invalid.
      d_valid = 1'b1;
      d_wr    = 1'b1;
      d_addr  = 32'h0000_0010;
      d_wdata = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      d_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst.ready",      {31'd0, o_ready}, 32'd1);
      check("midrst.resp_valid", {31'd0, o_resp_valid}, 32'd0);
      check("midrst.rdata",      o_resp_rdata, 32'd0);
      check("midrst.hit_count",  32'(o_hit_cnt), 32'd0);
      check("midrst.miss_count", 32'(o_miss_cnt), 32'd0);
      n_stray = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (o_resp_valid) n_stray++;
      end
      check("midrst.no_resp", 32'(n_stray), 32'd0);
      req_check("rd10", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0, 3);
      req_check("rd44c", 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0, 3);
      req_check("rd0Bc", 1'b0, 32'h0000_000B, 32'h0, 1'b0, 32'h0, 3);
      check("midrst.miss_after", 32'(o_miss_cnt), STATS ? 32'd3 : 32'd0);

      // LATENCY=1 instance.
      sel = 1'b1;
      @(negedge clk);
      req_check("l1rd00", 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 1);
      req_check("l1wr20", 1'b1, 32'h0000_0020, 32'hCAFE_0001, 1'b1, 32'h0, 1);
      req_check("l1rd20", 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'hCAFE_0001, 1);
      check("l1.hit_count",  32'(o_hit_cnt),  STATS ? 32'd1 : 32'd0);
      check("l1.miss_count", 32'(o_miss_cnt), STATS ? 32'd1 : 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
